// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite encodings: response codes, default protection bits and the error decode.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_order_fifo.sv
// In-order tag FIFO: one-cycle write-to-head latency; push is ignored when full and pop is ignored when empty.
// A push and a pop in the same cycle leave the count unchanged.
module axi_lite_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o     = (r_count == CW'(DEPTH));
  assign empty_o    = (r_count == '0);
  assign count_o    = r_count;
  assign head_dat_o = r_mem[r_rd_ptr];
  assign w_push     = push_i && !full_o;
  assign w_pop      = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_master_pipe.sv
// Request-to-AXI4-Lite master: request issues on AW/W or AR the next cycle, response is registered one cycle after B/R.
// Requests stall while any address/data slot is busy or the tag FIFO is full; B/R stall until they match the oldest tag.
module axi_lite_master_pipe
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_we_o,
  output logic                rsp_err_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [2:0]          awprot_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [2:0]          arprot_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUTST) + 1;

  logic              r_aw_vld;
  logic              r_w_vld;
  logic              r_ar_vld;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_rsp_vld;
  logic              r_rsp_we;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_run;
  logic              w_slots_empty;
  logic              w_room;
  logic              w_req_fire;
  logic              w_rsp_free;
  logic              w_b_fire;
  logic              w_r_fire;
  logic              w_pop;
  logic              w_head_we;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  axi_lite_order_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (1)
  ) u_order_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (w_req_fire),
    .push_dat_i (req_we_i),
    .pop_i      (w_pop),
    .head_dat_o (w_head_we),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .count_o    (w_count)
  );

  // No same-cycle bypass: a full FIFO blocks requests even while a response pops.
  assign w_run         = !reset_i;
  assign w_slots_empty = !r_aw_vld && !r_w_vld && !r_ar_vld;
  assign w_room        = !w_full && (w_count < CNT_W'(MAX_OUTST));
  assign req_ready_o   = w_run && w_slots_empty && w_room;
  assign w_req_fire    = req_valid_i && req_ready_o;

  assign w_rsp_free = !r_rsp_vld || rsp_ready_i;
  assign bready_o   = w_run && !w_empty && w_head_we && w_rsp_free;
  assign rready_o   = w_run && !w_empty && !w_head_we && w_rsp_free;
  assign w_b_fire   = bvalid_i && bready_o;
  assign w_r_fire   = rvalid_i && rready_o;
  assign w_pop      = w_b_fire || w_r_fire;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_aw_vld    <= 1'b0;
      r_w_vld     <= 1'b0;
      r_ar_vld    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      // Payload only loads when all slots are idle, so it is stable for every valid.
      if (w_req_fire) begin
        r_addr <= req_addr_i;
        if (req_we_i) begin
          r_aw_vld <= 1'b1;
          r_w_vld  <= 1'b1;
          r_wdata  <= req_wdata_i;
          r_wstrb  <= req_wstrb_i;
        end else begin
          r_ar_vld <= 1'b1;
        end
      end else begin
        if (r_aw_vld && awready_i) r_aw_vld <= 1'b0;
        if (r_w_vld && wready_i)   r_w_vld  <= 1'b0;
        if (r_ar_vld && arready_i) r_ar_vld <= 1'b0;
      end

      if (w_pop) begin
        r_rsp_vld   <= 1'b1;
        r_rsp_we    <= w_head_we;
        r_rsp_err   <= w_head_we ? resp_is_err(bresp_i) : resp_is_err(rresp_i);
        r_rsp_rdata <= w_head_we ? '0 : rdata_i;
      end else if (rsp_ready_i) begin
        r_rsp_vld <= 1'b0;
      end
    end
  end

  assign awvalid_o   = w_run && r_aw_vld;
  assign wvalid_o    = w_run && r_w_vld;
  assign arvalid_o   = w_run && r_ar_vld;
  assign awaddr_o    = w_run ? r_addr : '0;
  assign araddr_o    = w_run ? r_addr : '0;
  assign wdata_o     = w_run ? r_wdata : '0;
  assign wstrb_o     = w_run ? r_wstrb : '0;
  assign awprot_o    = AXI_PROT_DEFAULT;
  assign arprot_o    = AXI_PROT_DEFAULT;
  assign rsp_valid_o = w_run && r_rsp_vld;
  assign rsp_we_o    = w_run && r_rsp_we;
  assign rsp_err_o   = w_run && r_rsp_err;
  assign rsp_rdata_o = w_run ? r_rsp_rdata : '0;

endmodule

// File: tb/tb_axi_lite_master_pipe.sv
// Directed bench for axi_lite_master_pipe with a response scoreboard fed by the stimulus and drained by a monitor.
module tb_axi_lite_master_pipe;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_OUTST = 4;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                req_valid_i;
  logic                req_ready_o;
  logic                req_we_i;
  logic [ADDR_W-1:0]   req_addr_i;
  logic [DATA_W-1:0]   req_wdata_i;
  logic [DATA_W/8-1:0] req_wstrb_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic                rsp_we_o;
  logic                rsp_err_o;
  logic [DATA_W-1:0]   rsp_rdata_o;
  logic                awvalid_o;
  logic                awready_i;
  logic [ADDR_W-1:0]   awaddr_o;
  logic [2:0]          awprot_o;
  logic                wvalid_o;
  logic                wready_i;
  logic [DATA_W-1:0]   wdata_o;
  logic [DATA_W/8-1:0] wstrb_o;
  logic                bvalid_i;
  logic                bready_o;
  logic [1:0]          bresp_i;
  logic                arvalid_o;
  logic                arready_i;
  logic [ADDR_W-1:0]   araddr_o;
  logic [2:0]          arprot_o;
  logic                rvalid_i;
  logic                rready_o;
  logic [DATA_W-1:0]   rdata_i;
  logic [1:0]          rresp_i;

  typedef struct packed {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  axi_lite_master_pipe #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_we_o    (rsp_we_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_rdata_o (rsp_rdata_o),
    .awvalid_o   (awvalid_o),
    .awready_i   (awready_i),
    .awaddr_o    (awaddr_o),
    .awprot_o    (awprot_o),
    .wvalid_o    (wvalid_o),
    .wready_i    (wready_i),
    .wdata_o     (wdata_o),
    .wstrb_o     (wstrb_o),
    .bvalid_i    (bvalid_i),
    .bready_o    (bready_o),
    .bresp_i     (bresp_i),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready_i),
    .araddr_o    (araddr_o),
    .arprot_o    (arprot_o),
    .rvalid_i    (rvalid_i),
    .rready_o    (rready_o),
    .rdata_i     (rdata_i),
    .rresp_i     (rresp_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Each negedge with valid&ready high precedes exactly one response handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got we=%0d err=%0d rdata=0x%0h, expected no response", rsp_we_o, rsp_err_o, rsp_rdata_o);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_scoreboard", {rsp_we_o, rsp_err_o, rsp_rdata_o}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int n = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = wstrb;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic aw_w_accept();
    chk("awvalid_pre_hs", awvalid_o, 1);
    chk("wvalid_pre_hs", wvalid_o, 1);
    awready_i = 1'b1;
    wready_i  = 1'b1;
    tick();
    awready_i = 1'b0;
    wready_i  = 1'b0;
  endtask

  task automatic ar_accept();
    chk("arvalid_pre_hs", arvalid_o, 1);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
  endtask

  task automatic b_beat(input logic [1:0] resp);
    int n = 0;
    bvalid_i = 1'b1;
    bresp_i  = resp;
    while (!bready_o && n < 50) begin
      tick();
      n++;
    end
    chk("bready_wait", bready_o, 1);
    tick();
    bvalid_i = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    rvalid_i = 1'b1;
    rdata_i  = data;
    rresp_i  = resp;
    while (!rready_o && n < 50) begin
      tick();
      n++;
    end
    chk("rready_wait", rready_o, 1);
    tick();
    rvalid_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc;
    reset_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    rsp_ready_i = 1'b1;
    awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
    bvalid_i = 1'b0; bresp_i = 2'b00;
    rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;

    // Reset state
    repeat (2) tick();
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_valids", {rsp_valid_o, awvalid_o, wvalid_o, arvalid_o}, 0);
    chk("rst_readies", {bready_o, rready_o}, 0);
    chk("rst_data", {awaddr_o, wdata_o, rsp_rdata_o}, 0);
    reset_i = 1'b0;
    #1;
    chk("req_ready_after_rst", req_ready_o, 1);
    tick();

    // Write with AW taken two cycles before W
    sb_q.push_back('{we: 1'b1, err: 1'b0, rdata: 32'h0});
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr_awvalid", awvalid_o, 1);
    chk("wr_wvalid", wvalid_o, 1);
    chk("wr_awaddr", awaddr_o, 32'h10);
    chk("wr_prot", {awprot_o, arprot_o}, 0);
    chk("wr_req_ready_busy", req_ready_o, 0);
    awready_i = 1'b1;
    tick();
    awready_i = 1'b0;
    chk("wr_aw_dropped", awvalid_o, 0);
    chk("wr_w_held", wvalid_o, 1);
    tick();
    chk("wr_w_held2", wvalid_o, 1);
    chk("wr_wdata_stable", {wdata_o, wstrb_o}, {32'hDEADBEEF, 4'hF});
    wready_i = 1'b1;
    tick();
    wready_i = 1'b0;
    chk("wr_w_dropped", wvalid_o, 0);
    b_beat(2'b00);
    chk("wr_rsp_valid_n1", rsp_valid_o, 1);
    tick();

    // Read with SLVERR
    sb_q.push_back('{we: 1'b0, err: 1'b1, rdata: 32'h12345678});
    send(1'b0, 32'h20, 32'h0, 4'h0);
    chk("rd_araddr", araddr_o, 32'h20);
    ar_accept();
    r_beat(32'h12345678, 2'b10);
    tick();

    // Five back-to-back reads against a slave withholding R
    acc = 0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h40;
    arready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready_o) acc++;
      tick();
    end
    req_valid_i = 1'b0;
    arready_i = 1'b0;
    chk("outst_accepted", acc, 4);
    chk("outst_ready_low", req_ready_o, 0);
    for (int i = 0; i < 4; i++) sb_q.push_back('{we: 1'b0, err: 1'b0, rdata: 32'hA0000000 + i});
    rvalid_i = 1'b1; rdata_i = 32'hA0000000; rresp_i = 2'b00;
    chk("outst_rready", rready_o, 1);
    chk("outst_full_pop_no_ready", req_ready_o, 0);
    tick();
    rvalid_i = 1'b0;
    chk("outst_ready_after_r", req_ready_o, 1);
    for (int i = 1; i < 4; i++) r_beat(32'hA0000000 + i, 2'b00);
    tick();

    // R arrives before B: held back until B is taken
    sb_q.push_back('{we: 1'b1, err: 1'b0, rdata: 32'h0});
    sb_q.push_back('{we: 1'b0, err: 1'b0, rdata: 32'hCAFEF00D});
    send(1'b1, 32'h50, 32'h0BADF00D, 4'h3);
    aw_w_accept();
    send(1'b0, 32'h54, 32'h0, 4'h0);
    ar_accept();
    rvalid_i = 1'b1; rdata_i = 32'hCAFEF00D; rresp_i = 2'b00;
    repeat (3) tick();
    chk("ooo_rready_low", rready_o, 0);
    b_beat(2'b01);
    chk("ooo_rready_high", rready_o, 1);
    tick();
    rvalid_i = 1'b0;
    tick();

    // Zero-wait read slave: one request every two cycles
    acc = 0;
    arready_i = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'h55; rresp_i = 2'b00;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h60;
    for (int i = 0; i < 8; i++) begin
      if (req_ready_o) begin
        acc++;
        sb_q.push_back('{we: 1'b0, err: 1'b0, rdata: 32'h55});
      end
      tick();
    end
    req_valid_i = 1'b0;
    arready_i = 1'b0;
    rvalid_i = 1'b0;
    chk("thru_accepted", acc, 4);
    tick();

    // Response back-pressure keeps rsp_* stable and blocks the next R
    sb_q.push_back('{we: 1'b0, err: 1'b0, rdata: 32'h11111111});
    sb_q.push_back('{we: 1'b0, err: 1'b1, rdata: 32'h22222222});
    rsp_ready_i = 1'b0;
    send(1'b0, 32'h30, 32'h0, 4'h0);
    ar_accept();
    send(1'b0, 32'h34, 32'h0, 4'h0);
    ar_accept();
    r_beat(32'h11111111, 2'b00);
    rvalid_i = 1'b1; rdata_i = 32'h22222222; rresp_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_stable", {rsp_valid_o, rsp_we_o, rsp_err_o, rsp_rdata_o}, {3'b100, 32'h11111111});
      chk("bp_rready_low", rready_o, 0);
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_rready_drain", rready_o, 1);
    tick();
    rvalid_i = 1'b0;
    repeat (2) tick();

    // Reset pulse with two reads outstanding
    send(1'b0, 32'h70, 32'h0, 4'h0);
    ar_accept();
    send(1'b0, 32'h74, 32'h0, 4'h0);
    ar_accept();
    reset_i = 1'b1;
    #1;
    chk("midrst_outputs", {req_ready_o, rsp_valid_o, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}, 0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready_o, 1);
    chk("midrst_valids", {rsp_valid_o, arvalid_o, awvalid_o}, 0);
    rvalid_i = 1'b1; rdata_i = 32'hBAD0BAD0; rresp_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("stale_r_ignored", rready_o, 0);
      tick();
    end
    rvalid_i = 1'b0;

    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_pipe.md
AXI_LITE_MASTER_PIPE -- requirements
Module: axi_lite_master_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the request and AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width; legal values are 32 and 64; strobe width is DATA_W/8.
REQ-003 SHALL have parameter MAX_OUTST, default 4, the maximum issued-but-unresponded transactions; legal range is 1..16, power of two.
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_i  in  1  sole clock, rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- req_valid_i / req_ready_o  in/out  1/1  request handshake.
- req_we_i, req_addr_i, req_wdata_i, req_wstrb_i  in  1, ADDR_W, DATA_W, DATA_W/8  request payload.
- rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
- rsp_we_o, rsp_err_o, rsp_rdata_o  out  1, 1, DATA_W  response kind, error flag, read data.
- awvalid_o, awready_i, awaddr_o, awprot_o  out/in/out/out  1, 1, ADDR_W, 3  AXI write address channel.
- wvalid_o, wready_i, wdata_o, wstrb_o  out/in/out/out  1, 1, DATA_W, DATA_W/8  AXI write data channel.
- bvalid_i, bready_o, bresp_i  in/out/in  1, 1, 2  AXI write response channel.
- arvalid_o, arready_i, araddr_o, arprot_o  out/in/out/out  1, 1, ADDR_W, 3  AXI read address channel.
- rvalid_i, rready_o, rdata_i, rresp_i  in/out/in/in  1, 1, DATA_W, 2  AXI read data channel.

Function
REQ-005 SHALL assert req_ready_o only when AW, W and AR slots are all empty and the outstanding count is below MAX_OUTST; req_ready_o SHALL NOT depend on req_valid_i.
REQ-006 SHALL, on a write accepted at edge N, assert awvalid_o and wvalid_o in cycle N+1; on a read, arvalid_o in cycle N+1.
REQ-007 SHALL drop AW and W independently, each on its own handshake, in either order or together; payload SHALL stay stable while valid is high.
REQ-008 SHALL drive awprot_o and arprot_o to 3'b000.
REQ-009 SHALL push req_we_i into an in-order tag FIFO (depth MAX_OUTST) on each accepted request; the outstanding count equals FIFO occupancy.
REQ-010 SHALL assert bready_o only when the FIFO head is a write and the response register is empty or draining this cycle; rready_o likewise for a read head. Responses arriving out of request order SHALL be back-pressured.
REQ-011 SHALL pop the FIFO on each B or R handshake and load the response register, asserting rsp_valid_o in cycle N+1 for a handshake at edge N.
REQ-012 SHALL set rsp_err_o = resp[1] (SLVERR/DECERR), rsp_we_o = popped tag, and rsp_rdata_o = rdata_i for reads or 0 for writes.
REQ-013 SHALL hold the rsp_* outputs stable while rsp_valid_o && !rsp_ready_i.
REQ-014 SHALL treat a push and a pop in the same cycle as count-neutral; when the count equals MAX_OUTST, req_ready_o SHALL stay low even if a pop occurs in that cycle.
REQ-015 SHALL sustain one transaction per two cycles against a zero-wait slave with rsp_ready_i held high.

Reset
REQ-016 SHALL, while reset_i is high at a clock edge, clear the FIFO, the count, all slots and the response register.
REQ-017 SHALL force req_ready_o, rsp_valid_o, awvalid_o, wvalid_o, arvalid_o, bready_o and rready_o to 0, and all data outputs to 0, during reset.
REQ-018 SHALL, on reset asserted mid-transaction, abandon in-flight transactions; later B/R beats are never accepted because bready_o and rready_o stay 0 while the FIFO is empty.
REQ-019 SHALL assert req_ready_o in the first cycle after reset_i deasserts.

Structure
REQ-020 SHALL take the resp encodings (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) and the default prot constant from shared package axi_lite_pkg.
REQ-021 SHALL implement the tag FIFO as sub-module axi_lite_order_fifo (parametrised depth and width, with full, empty and count outputs).

Verification
REQ-022 Write addr 0x10, data 0xDEADBEEF, strb 0xF, awready 2 cycles before wready, bresp OKAY -> AW and W drop independently; one response with we=1, err=0, rdata=0.
REQ-023 Read addr 0x20, rdata 0x12345678, rresp SLVERR -> response with we=0, err=1, rdata=0x12345678.
REQ-024 MAX_OUTST=4, five back-to-back reads, slave withholding R -> exactly 4 accepted; req_ready_o low until the first R handshake.
REQ-025 Write then read issued; slave presents R before B -> rready_o held low until B is taken; responses delivered in order write, read.
REQ-026 rsp_ready_i low for 5 cycles with a pending response -> rsp_* stable; the next bready_o/rready_o stays low.
REQ-027 reset_i pulsed for 1 cycle with 2 reads outstanding -> all valids 0, req_ready_o=1 the next cycle, a stale R beat ignored.
